// File: rtl/peecc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : peecc_pkg
//  Description : Shared definitions for the PEECC link pipeline: default bus
//                and accumulator widths, and the transition-counter FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package peecc_pkg;

    // Encoded bus width (data plus check bits) and accumulator width
    localparam int DEF_WIDTH = 38;
    localparam int DEF_CNT_W = 32;

    // Transition-counter states; the unused code 2'd3 recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_REPORT = 2'd2,
        ST_RSVD   = 2'd3
    } tc_state_t;

endpackage : peecc_pkg
`default_nettype wire

// File: rtl/bus_activity_calc.sv
`default_nettype none
// ============================================================================
//  Module      : bus_activity_calc
//  Description : Combinational per-word switching metrics between two bus
//                words: self transitions (toggling wires) and coupling
//                transitions (adjacent wires toggling in opposite directions).
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_activity_calc #(
    parameter int WIDTH = 38,
    parameter int SW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] cur,
    output logic [SW-1:0]    self_cnt,
    output logic [SW-1:0]    coup_cnt
);

    logic [WIDTH-1:0] w_diff;

    assign w_diff = prev ^ cur;

    // Popcount of toggles, and count of adjacent pairs that swap (01<->10)
    always_comb begin
        self_cnt = '0;
        coup_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            self_cnt = self_cnt + SW'(w_diff[i]);
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            // Both toggle and started different -> they moved in opposite directions
            if (w_diff[i] && w_diff[i+1] && (prev[i] != prev[i+1])) begin
                coup_cnt = coup_cnt + SW'(1);
            end
        end
    end

endmodule : bus_activity_calc
`default_nettype wire

// File: rtl/bus_transition_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_transition_counter
//  Description : Frame-based switching-activity meter for the encoded bus.
//                Primes on the first enabled word, accumulates self and
//                coupling transitions with saturating counters, and pulses
//                result_valid for one cycle when the frame ends or aborts.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_transition_counter
    import peecc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             frame_end,
    input  logic [WIDTH-1:0] bus_in,
    output logic [CNT_W-1:0] self_count,
    output logic [CNT_W-1:0] coupling_count,
    output logic [CNT_W-1:0] word_count,
    output logic             result_valid,
    output logic             overflow
);

    localparam int c_SW = $clog2(WIDTH + 1);

    tc_state_t        r_state;
    tc_state_t        w_next_state;
    logic [WIDTH-1:0] r_prev;
    logic [CNT_W-1:0] r_self;
    logic [CNT_W-1:0] r_coup;
    logic [CNT_W-1:0] r_word;
    logic             r_overflow;

    logic [c_SW-1:0]  w_self_inc;
    logic [c_SW-1:0]  w_coup_inc;
    logic [CNT_W:0]   w_self_sum;
    logic [CNT_W:0]   w_coup_sum;
    logic [CNT_W:0]   w_word_sum;
    logic [CNT_W-1:0] w_self_sat;
    logic [CNT_W-1:0] w_coup_sat;
    logic [CNT_W-1:0] w_word_sat;
    logic             w_any_sat;

    bus_activity_calc #(
        .WIDTH (WIDTH),
        .SW    (c_SW)
    ) u_calc (
        .prev     (r_prev),
        .cur      (bus_in),
        .self_cnt (w_self_inc),
        .coup_cnt (w_coup_inc)
    );

    // Saturating adds: the extra top bit is the carry that triggers clamping
    always_comb begin
        w_self_sum = {1'b0, r_self} + (CNT_W+1)'(w_self_inc);
        w_coup_sum = {1'b0, r_coup} + (CNT_W+1)'(w_coup_inc);
        w_word_sum = {1'b0, r_word} + (CNT_W+1)'(1);
        w_self_sat = w_self_sum[CNT_W] ? '1 : w_self_sum[CNT_W-1:0];
        w_coup_sat = w_coup_sum[CNT_W] ? '1 : w_coup_sum[CNT_W-1:0];
        w_word_sat = w_word_sum[CNT_W] ? '1 : w_word_sum[CNT_W-1:0];
        w_any_sat  = w_self_sum[CNT_W] | w_coup_sum[CNT_W] | w_word_sum[CNT_W];
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; en/frame_end are don't-care during REPORT
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_next_state = frame_end ? ST_REPORT : ST_COUNT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (!en || frame_end) begin
                    w_next_state = ST_REPORT;
                end else begin
                    w_next_state = ST_COUNT;
                end
            end
            ST_REPORT: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: priming in IDLE, accumulation in COUNT, hold otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev     <= '0;
            r_self     <= '0;
            r_coup     <= '0;
            r_word     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && en) begin
                r_prev     <= bus_in;
                r_self     <= '0;
                r_coup     <= '0;
                r_word     <= CNT_W'(1);
                r_overflow <= 1'b0;
            end else if (r_state == ST_COUNT && en) begin
                r_prev     <= bus_in;
                r_self     <= w_self_sat;
                r_coup     <= w_coup_sat;
                r_word     <= w_word_sat;
                r_overflow <= r_overflow | w_any_sat;
            end
        end
    end

    assign self_count     = r_self;
    assign coupling_count = r_coup;
    assign word_count     = r_word;
    assign overflow       = r_overflow;
    assign result_valid   = (r_state == ST_REPORT);

endmodule : bus_transition_counter
`default_nettype wire

// File: doc/bus_transition_counter.md
# bus_transition_counter

Measures switching activity on the encoded interconnect bus for one frame of the PEECC link pipeline. Sits directly downstream of the link controller: driven by its `en_trans_count` and `done` strobes, it samples the bus word every cycle. It accumulates self transitions (wire toggles) and coupling transitions (adjacent wires toggling in opposite directions). At frame end it reports totals for the power comparison against the uncoded bus.

## Interface
Parameters:
- `WIDTH`, 38: bus width in wires (data plus check bits).
- `CNT_W`, 32: width of each accumulator.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `en` input 1: count enable, driven from the controller's `en_trans_count`.
- `frame_end` input 1: last-word marker, driven from the controller's `done`.
- `bus_in` input WIDTH: encoded bus word for the current cycle.
- `self_count` output CNT_W: accumulated self transitions.
- `coupling_count` output CNT_W: accumulated opposite-direction adjacent transitions.
- `word_count` output CNT_W: number of words sampled in the frame, including the priming word.
- `result_valid` output 1: one-cycle pulse when the totals are final.
- `overflow` output 1: sticky flag, set when any accumulator has saturated during the frame.

## Operation
- States:
  - IDLE: waiting for a frame.
  - COUNT: accumulating.
  - REPORT: one cycle, asserts `result_valid`.
- Per-word metrics use `prev` (the last captured word) and `cur` (`bus_in`).
  - self = popcount(prev ^ cur).
  - coupling = number of i in 0..WIDTH-2 where bit i and bit i+1 both toggle and prev[i] != prev[i+1]. These are the 01→10 and 10→01 pairs.
  - Per-word self is at most WIDTH. Per-word coupling is at most WIDTH-1.
- IDLE with `en`=1:
  - Capture `bus_in` into `prev`.
  - Clear `self_count` and `coupling_count` to 0, set `word_count` to 1, clear `overflow`.
  - Go to COUNT. If `frame_end`=1 in the same cycle, go to REPORT instead.
- IDLE with `en`=0: hold all outputs and `prev`. Last results stay readable.
- COUNT with `en`=1:
  - Add self and coupling to the accumulators, increment `word_count`, and set `prev` to `bus_in`.
  - Stay in COUNT, or go to REPORT if `frame_end`=1. The frame_end word is counted.
- COUNT with `en`=0: early abort. Go to REPORT with no accumulation for that cycle.
- REPORT:
  - `result_valid`=1 for exactly one cycle, then go to IDLE.
  - `en` and `frame_end` are ignored in this cycle. A new frame can prime on the following IDLE cycle.
- Arithmetic: accumulators are CNT_W bits wide and saturate at all-ones, never wrapping. Any saturation sets `overflow`, which holds until the next priming.
- `frame_end` with `en`=0 has no effect in any state.

## Timing
- Reset (asynchronous, `reset_n`=0):
  - State goes to IDLE.
  - `self_count`, `coupling_count`, `word_count`, `prev` = 0.
  - `result_valid`, `overflow` = 0.
  - Reset mid-frame discards the partial totals immediately.
- Accumulators update on the clock edge that samples the word, so totals are visible the next cycle.
- `result_valid` rises one cycle after the edge that samples `frame_end`=1 (or `en`=0 in COUNT). Counts are already final and stable during the `result_valid` cycle.
- Minimum frame: prime with `frame_end`=1 in IDLE. This gives `result_valid` one cycle later with self=0, coupling=0, word=1.
- Throughput: one word per cycle. There is one dead cycle (REPORT) between consecutive frames.

## Structure
- Shared package `peecc_pkg`:
  - State encodings: IDLE=2'd0, COUNT=2'd1, REPORT=2'd2; 2'd3 recovers to IDLE.
  - Default `WIDTH` and `CNT_W` constants, shared with the controller and encoder.
- One sub-module, `bus_activity_calc`: purely combinational. It takes prev/cur and produces the per-word self and coupling counts, each $clog2(WIDTH+1) bits. It is reused by the uncoded-bus reference counter.
- The top level holds the FSM, the `prev` register, the saturating accumulators and the overflow flag.

## Test plan
All scenarios use WIDTH=4 and CNT_W=8 unless noted.
- **Toggle frame:** `en`=1 for words 0000, 1111, 0000, with `frame_end` on the third word.
  - One cycle later: `result_valid` pulses once; self=8, coupling=0, word=3, overflow=0.
- **Coupling:** words 0101, 1010, with `frame_end` on the second word.
  - Result: self=4, coupling=3, word=2.
- **Early abort:** words 0000, 0001, then `en` drops without `frame_end`.
  - Next cycle: `result_valid`=1; self=1, coupling=0, word=2.
- **Saturation:** CNT_W=4, alternate 0000/1111 for 6 words with `frame_end` on the last.
  - Result: self=15 (saturated, not 20 mod 16), overflow=1.
  - Overflow clears when the next frame primes.
- **Reset mid-frame:** assert `reset_n`=0 after 3 COUNT words.
  - All outputs read 0 asynchronously and state is IDLE.
  - A following frame 0011, 0000 gives self=2.
- **Back-to-back frames:** raise `en` again in the cycle after REPORT.
  - The new frame primes with counters cleared.
  - The `en` value seen during the REPORT cycle is ignored.
